// File: rtl/secuenciador_autoprueba_secded_if.sv
// Datapath-side bus between the SECDED self-test sequencer (master) and the
// encoder/decoder/corrector under test (slave).
interface secuenciador_autoprueba_secded_if;
  logic [3:0] dato_entrada;
  logic [7:0] dato_error;
  logic [7:0] palabra_codificada;
  logic [3:0] corregido;
  logic       simplerror_detectado;
  logic       doblerror_detectado;

  modport master (
    output dato_entrada,
    output dato_error,
    input  palabra_codificada,
    input  corregido,
    input  simplerror_detectado,
    input  doblerror_detectado
  );

  modport slave (
    input  dato_entrada,
    input  dato_error,
    output palabra_codificada,
    output corregido,
    output simplerror_detectado,
    output doblerror_detectado
  );
endinterface

// File: rtl/secuenciador_autoprueba_secded.sv
// Built-in self-test sequencer for the (8,4) SECDED datapath: sweeps all data
// values against 11 error masks. Optional macro PARAR_EN_FALLO_EN stops at the first failure.
module secuenciador_autoprueba_secded #(
  parameter int LAT_COD = 2,
  parameter int LAT_DEC = 2
) (
  input  logic                                   reloj,
  input  logic                                   reset,
  input  logic                                   iniciar,
  secuenciador_autoprueba_secded_if.master       dp,
  output logic                                   ocupado,
  output logic                                   hecho,
  output logic                                   exito,
  output logic [7:0]                             cuenta_fallos,
  output logic [3:0]                             fallo_dato,
  output logic [3:0]                             fallo_patron
);

  localparam logic [2:0] REPOSO   = 3'd0;
  localparam logic [2:0] CODIFICA = 3'd1;
  localparam logic [2:0] INYECTA  = 3'd2;
  localparam logic [2:0] ESPERA   = 3'd3;
  localparam logic [2:0] VERIFICA = 3'd4;
  localparam logic [2:0] AVANZA   = 3'd5;
  localparam logic [2:0] FIN      = 3'd6;

  // CODIFICA spans LAT_COD+1 cycles, ESPERA spans LAT_DEC cycles
  localparam logic [2:0] FIN_COD = 3'(LAT_COD);
  localparam logic [2:0] FIN_DEC = 3'(LAT_DEC - 1);

  logic [2:0] estado;
  logic [2:0] contador;
  logic [3:0] patron;
  logic [3:0] dato_r;
  logic [7:0] error_r;
  logic       pasa;

  assign dp.dato_entrada = dato_r;
  assign dp.dato_error   = error_r;

  function automatic logic [7:0] mascara(input logic [3:0] p);
    logic [7:0] m;
    m = '0;
    case (p)
      4'd1:    m = 8'h01;
      4'd2:    m = 8'h02;
      4'd3:    m = 8'h04;
      4'd4:    m = 8'h08;
      4'd5:    m = 8'h10;
      4'd6:    m = 8'h20;
      4'd7:    m = 8'h40;
      4'd8:    m = 8'h80;
      4'd9:    m = 8'h03;
      4'd10:   m = 8'h81;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  always_comb begin
    pasa = 1'b0;
    if (patron == 4'd0)
      pasa = !dp.simplerror_detectado && !dp.doblerror_detectado &&
             (dp.corregido == dato_r);
    else if (patron <= 4'd8)
      pasa = dp.simplerror_detectado && !dp.doblerror_detectado &&
             (dp.corregido == dato_r);
    else
      pasa = !dp.simplerror_detectado && dp.doblerror_detectado;
  end

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      estado        <= REPOSO;
      contador      <= '0;
      patron        <= '0;
      dato_r        <= '0;
      error_r       <= '0;
      ocupado       <= 1'b0;
      hecho         <= 1'b0;
      exito         <= 1'b0;
      cuenta_fallos <= '0;
      fallo_dato    <= '0;
      fallo_patron  <= '0;
    end else begin
      case (estado)
        REPOSO: begin
          if (iniciar) begin
            cuenta_fallos <= '0;
            fallo_dato    <= '0;
            fallo_patron  <= '0;
            hecho         <= 1'b0;
            exito         <= 1'b0;
            dato_r        <= '0;
            patron        <= '0;
            contador      <= '0;
            ocupado       <= 1'b1;
            estado        <= CODIFICA;
          end
        end
        CODIFICA: begin
          if (contador == FIN_COD) begin
            contador <= '0;
            estado   <= INYECTA;
          end else begin
            contador <= contador + 3'd1;
          end
        end
        INYECTA: begin
          error_r  <= dp.palabra_codificada ^ mascara(patron);
          contador <= '0;
          estado   <= ESPERA;
        end
        ESPERA: begin
          if (contador == FIN_DEC) begin
            contador <= '0;
            estado   <= VERIFICA;
          end else begin
            contador <= contador + 3'd1;
          end
        end
        VERIFICA: begin
          estado <= AVANZA;
          if (!pasa) begin
            if (cuenta_fallos != 8'hFF)
              cuenta_fallos <= cuenta_fallos + 8'd1;
            if (cuenta_fallos == 8'd0) begin
              fallo_dato   <= dato_r;
              fallo_patron <= patron;
            end
`ifdef PARAR_EN_FALLO_EN
            estado <= FIN;
`else
            estado <= AVANZA;
`endif
          end
        end
        AVANZA: begin
          // Data is unchanged across patterns, so only a new data value re-encodes
          if (patron != 4'd10) begin
            patron <= patron + 4'd1;
            estado <= INYECTA;
          end else if (dato_r != 4'd15) begin
            dato_r   <= dato_r + 4'd1;
            patron   <= '0;
            contador <= '0;
            estado   <= CODIFICA;
          end else begin
            estado <= FIN;
          end
        end
        FIN: begin
          ocupado <= 1'b0;
          hecho   <= 1'b1;
          exito   <= (cuenta_fallos == 8'd0);
          estado  <= REPOSO;
        end
        default: estado <= REPOSO;
      endcase
    end
  end

endmodule
